// File: rtl/gray_to_binary_tracker_if.sv
// Port bundle for gray_to_binary_tracker: enable/clear controls, Gray input, decoded outputs.
// err_cnt exists only when GRAY_ERR_CNT_EN is defined.
interface gray_to_binary_tracker_if #(parameter int WIDTH = 4);
  logic             en;
  logic             clr_err;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             step_pulse;
  logic [WIDTH-1:0] delta;
  logic             err_pulse;
  logic             err_sticky;
`ifdef GRAY_ERR_CNT_EN
  logic [7:0]       err_cnt;
`endif

  modport master (
`ifdef GRAY_ERR_CNT_EN
    input  err_cnt,
`endif
    output en, clr_err, gray_in,
    input  bin_out, bin_valid, step_pulse, delta, err_pulse, err_sticky
  );

  modport slave (
`ifdef GRAY_ERR_CNT_EN
    output err_cnt,
`endif
    input  en, clr_err, gray_in,
    output bin_out, bin_valid, step_pulse, delta, err_pulse, err_sticky
  );
endinterface

// File: rtl/gray_to_binary_tracker.sv
// Synchronises an asynchronous Gray count, decodes it and classifies each change as a legal
// one-code step or an illegal jump. Optional error counter enabled by GRAY_ERR_CNT_EN.
module gray_to_binary_tracker #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_to_binary_tracker_if.slave bus
);
  localparam int CW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {FILL, BASE, RUN} state_t;

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] g_sync;
  logic [WIDTH-1:0] bin_new;
  logic [WIDTH-1:0] diff;

  state_t           state_reg, state_next;
  logic [CW-1:0]    fill_cnt_reg, fill_cnt_next;
  logic [WIDTH-1:0] g_prev_reg, g_prev_next;
  logic [WIDTH-1:0] bin_out_reg, bin_out_next;
  logic [WIDTH-1:0] delta_reg, delta_next;
  logic             valid_reg, valid_next;
  logic             step_reg, step_next;
  logic             err_reg, err_next;
  logic             sticky_reg, sticky_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= bus.gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign g_sync = sync_reg[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at and above it.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_decode
      assign bin_new[gi] = ^g_sync[WIDTH-1:gi];
    end
  endgenerate

  assign diff = g_sync ^ g_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FILL;
      fill_cnt_reg <= '0;
      g_prev_reg   <= '0;
      bin_out_reg  <= '0;
      delta_reg    <= '0;
      valid_reg    <= 1'b0;
      step_reg     <= 1'b0;
      err_reg      <= 1'b0;
      sticky_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
      g_prev_reg   <= g_prev_next;
      bin_out_reg  <= bin_out_next;
      delta_reg    <= delta_next;
      valid_reg    <= valid_next;
      step_reg     <= step_next;
      err_reg      <= err_next;
      sticky_reg   <= sticky_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    g_prev_next   = g_prev_reg;
    bin_out_next  = bin_out_reg;
    valid_next    = valid_reg;
    step_next     = 1'b0;
    err_next      = 1'b0;
    delta_next    = '0;
    sticky_next   = sticky_reg & ~bus.clr_err;
    if (!bus.en) begin
      state_next    = FILL;
      fill_cnt_next = '0;
      valid_next    = 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          // Wait until the sync chain holds only post-enable samples.
          if (fill_cnt_reg == CW'(SYNC_STAGES - 1)) begin
            fill_cnt_next = '0;
            state_next    = BASE;
          end else begin
            fill_cnt_next = fill_cnt_reg + 1'b1;
          end
        end
        BASE: begin
          g_prev_next  = g_sync;
          bin_out_next = bin_new;
          valid_next   = 1'b1;
          state_next   = RUN;
        end
        RUN: begin
          if (diff != '0) begin
            g_prev_next  = g_sync;
            bin_out_next = bin_new;
            delta_next   = bin_new - bin_out_reg;
            if ((diff & (diff - 1'b1)) == '0) begin
              step_next = 1'b1;
            end else begin
              err_next    = 1'b1;
              sticky_next = 1'b1;
            end
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  assign bus.bin_out    = bin_out_reg;
  assign bus.bin_valid  = valid_reg;
  assign bus.step_pulse = step_reg;
  assign bus.delta      = delta_reg;
  assign bus.err_pulse  = err_reg;
  assign bus.err_sticky = sticky_reg;

`ifdef GRAY_ERR_CNT_EN
  logic [7:0] err_cnt_reg, err_cnt_next;

  // A new error takes priority over clr_err and restarts the count at one.
  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (err_next) begin
      if (bus.clr_err)               err_cnt_next = 8'd1;
      else if (err_cnt_reg != 8'hFF) err_cnt_next = err_cnt_reg + 8'd1;
    end else if (bus.clr_err) begin
      err_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_reg <= '0;
    else        err_cnt_reg <= err_cnt_next;
  end

  assign bus.err_cnt = err_cnt_reg;
`endif
endmodule
